fetch_sequencer: RTL

Instruction-fetch controller that sequences the 32x8 instruction ROM. It holds the program counter and drives the ROM read address. It captures the combinational ROM read data into a one-entry output register and hands instructions to the decode stage over a valid/ready handshake. It supports start, halt, jump/redirect, address wrap-around and out-of-range fault detection.

---
 rtl/fetch_sequencer.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, reads the instruction ROM and
// hands words to decode through a one-entry valid/ready output register.
module fetch_sequencer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ROM_DEPTH  = 32,
    parameter int START_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  halt_req,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  instr_valid,
    input  logic                  instr_ready,
    output logic [DATA_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0] instr_pc,
    output logic                  busy,
    output logic                  halted,
    output logic                  fault,
    output logic [15:0]           instr_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STALL,
        HALTED
    } state_e;

    localparam logic [ADDR_WIDTH-1:0] LAST_PC =
        ADDR_WIDTH'(ROM_DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] START_PC =
        ADDR_WIDTH'(START_ADDR);
    localparam logic [ADDR_WIDTH:0] DEPTH =
        (ADDR_WIDTH + 1)'(ROM_DEPTH);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic                    valid_q, valid_d;
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
    logic                    fault_q, fault_d;
    logic [15:0]             count_q, count_d;
    logic                    busy_q, halted_q;

    logic xfer;
    logic slot_free;
    logic jump_ok;

    assign xfer      = valid_q & instr_ready;
    assign slot_free = ~valid_q | instr_ready;
    assign jump_ok   = {1'b0, jump_addr} < DEPTH;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        out_d   = out_q;
        ipc_d   = ipc_q;
        fault_d = fault_q;
        count_d = count_q;
        // A word leaving on this edge counts even if a redirect flushes.
        if (xfer) begin
            count_d = count_q + 16'd1;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    pc_d    = START_PC;
                end
            end
            HALTED: begin
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH, STALL: begin
                if (jump_valid) begin
                    valid_d = 1'b0;
                    if (jump_ok) begin
                        pc_d    = jump_addr;
                        state_d = FETCH;
                    end else begin
                        fault_d = 1'b1;
                        state_d = HALTED;
                    end
                end else if (halt_req) begin
                    valid_d = 1'b0;
                    state_d = HALTED;
                end else if (state_q == STALL) begin
                    if (instr_ready) begin
                        valid_d = 1'b0;
                        state_d = FETCH;
                    end
                end else if (slot_free) begin
                    out_d   = rom_data;
                    ipc_d   = pc_q;
                    valid_d = 1'b1;
                    pc_d    = (pc_q == LAST_PC) ? '0
                            : pc_q + 1'b1;
                end else begin
                    state_d = STALL;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            pc_q     <= START_PC;
            valid_q  <= 1'b0;
            out_q    <= '0;
            ipc_q    <= '0;
            fault_q  <= 1'b0;
            count_q  <= '0;
            busy_q   <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            out_q    <= out_d;
            ipc_q    <= ipc_d;
            fault_q  <= fault_d;
            count_q  <= count_d;
            busy_q   <= (state_d == FETCH) ||
                        (state_d == STALL);
            halted_q <= (state_d == HALTED);
        end
    end

    assign rom_addr    = pc_q;
    assign instr_valid = valid_q;
    assign instr_out   = out_q;
    assign instr_pc    = ipc_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign instr_count = count_q;

endmodule
